// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the multicycle shift unit
// Purpose: op codes, amount-source selects and FSM state codes used by
//          shift_unit_seq and shift_amt_sel.
// Ports:   none (package).
package shift_pkg;

  localparam logic [2:0] SH_NOP  = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;
  localparam logic [2:0] SH_ROR  = 3'b101;
  localparam logic [2:0] SH_ROL  = 3'b110;
  localparam logic [2:0] SH_NOP2 = 3'b111;

  localparam logic [1:0] AMT_OFFSET = 2'b00;
  localparam logic [1:0] AMT_CONST  = 2'b01;
  localparam logic [1:0] AMT_REGB   = 2'b10;
  localparam logic [1:0] AMT_ZERO   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == SH_SLL) || (op == SH_SRL) || (op == SH_SRA) ||
           (op == SH_ROR) || (op == SH_ROL);
  endfunction

endpackage

// File: rtl/shift_amt_sel.sv
// rtl/shift_amt_sel.sv - combinational shift-amount source mux
// Purpose: picks the shift amount from the instruction offset field, a
//          constant, or register B; every select value gives a defined amount.
// Ports:   i_amt_sel  amount source select
//          i_offset   instruction immediate (amount in bits 10:6)
//          i_reg_b    register B (only the low SHAMT_W bits are used)
//          o_shamt    selected amount
module shift_amt_sel
  import shift_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SHAMT_W     = 5,
  parameter int CONST_SHAMT = 16
) (
  input  logic [1:0]         i_amt_sel,
  input  logic [15:0]        i_offset,
  input  logic [DATA_W-1:0]  i_reg_b,
  output logic [SHAMT_W-1:0] o_shamt
);

  // Upper source bits are deliberately dropped: the amount is mod DATA_W.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_offset, i_reg_b};

  always_comb begin
    o_shamt = '0;
    case (i_amt_sel)
      AMT_OFFSET: o_shamt = SHAMT_W'(i_offset[10:6]);
      AMT_CONST:  o_shamt = SHAMT_W'(CONST_SHAMT);
      AMT_REGB:   o_shamt = i_reg_b[SHAMT_W-1:0];
      AMT_ZERO:   o_shamt = '0;
      default:    o_shamt = '0;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multicycle logical/arithmetic/rotate shift unit
// Purpose: latches an operand and amount on an accepted start, then shifts
//          by up to STEP bits per cycle until the amount is consumed.
// Ports:   i_clk, i_reset (async, active-low)
//          i_start, i_op, i_amt_sel   request, operation, amount source
//          i_offset, i_reg_b          amount sources
//          i_data_in                  operand
//          o_busy, o_done             in progress / one-cycle completion
//          o_data_out, o_shamt_out    result register, latched amount
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SHAMT_W     = 5,
  parameter int STEP        = 1,
  parameter int CONST_SHAMT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [2:0]         i_op,
  input  logic [1:0]         i_amt_sel,
  input  logic [15:0]        i_offset,
  input  logic [DATA_W-1:0]  i_reg_b,
  input  logic [DATA_W-1:0]  i_data_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [DATA_W-1:0]  o_data_out,
  output logic [SHAMT_W-1:0] o_shamt_out
);

  // One extra bit so that STEP == DATA_W is representable.
  localparam int CNT_W = SHAMT_W + 1;

  logic [1:0]         r_state;
  logic [2:0]         r_op;
  logic [DATA_W-1:0]  r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [SHAMT_W-1:0] r_rem;
  logic [SHAMT_W-1:0] w_amt;
  logic [CNT_W-1:0]   w_k;

  shift_amt_sel #(
    .DATA_W      (DATA_W),
    .SHAMT_W     (SHAMT_W),
    .CONST_SHAMT (CONST_SHAMT)
  ) u_amt_sel (
    .i_amt_sel (i_amt_sel),
    .i_offset  (i_offset),
    .i_reg_b   (i_reg_b),
    .o_shamt   (w_amt)
  );

  // Shift by k (1..DATA_W-1 in use); rotates recombine the bits pushed out.
  function automatic logic [DATA_W-1:0] step_shift(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] d,
    input logic [CNT_W-1:0]  k
  );
    logic [CNT_W-1:0] kc;
    kc = CNT_W'(DATA_W) - k;
    case (op)
      SH_SLL:  return d << k;
      SH_SRL:  return d >> k;
      SH_SRA:  return $unsigned($signed(d) >>> k);
      SH_ROR:  return (d >> k) | (d << kc);
      SH_ROL:  return (d << k) | (d >> kc);
      default: return d;
    endcase
  endfunction

  assign w_k = ({1'b0, r_rem} > CNT_W'(STEP)) ? CNT_W'(STEP) : {1'b0, r_rem};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= SH_NOP;
      r_data  <= '0;
      r_shamt <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (is_shift_op(i_op)) begin
              r_data  <= i_data_in;
              r_op    <= i_op;
              r_shamt <= w_amt;
              r_rem   <= w_amt;
              r_state <= ST_SHIFT;
            end else if (i_op == SH_LOAD) begin
              r_data  <= i_data_in;
              r_state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (r_rem == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_data <= step_shift(r_op, r_data, w_k);
            r_rem  <= r_rem - w_k[SHAMT_W-1:0];
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state == ST_SHIFT);
  assign o_done      = (r_state == ST_DONE);
  assign o_data_out  = r_data;
  assign o_shamt_out = r_shamt;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - scoreboard bench for shift_unit_seq over several STEP values
module tb_shift_unit_seq;
  import shift_pkg::*;

  localparam int NI = 5;

  function automatic int step_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      default: return 32;
    endcase
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    bit          chk_sh;
    int          cyc;
  } exp_t;

  exp_t sb_q [NI][$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  amt_sel = '0;
  logic [15:0] offset = '0;
  logic [31:0] reg_b = '0;
  logic [31:0] data_in = '0;
  logic        w_busy [NI];
  logic        w_done [NI];
  logic [31:0] w_dout [NI];
  logic [4:0]  w_shq  [NI];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ST = step_of(g);
    shift_unit_seq #(
      .DATA_W      (32),
      .SHAMT_W     (5),
      .STEP        (ST),
      .CONST_SHAMT (16)
    ) u_dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_op        (op),
      .i_amt_sel   (amt_sel),
      .i_offset    (offset),
      .i_reg_b     (reg_b),
      .i_data_in   (data_in),
      .o_busy      (w_busy[g]),
      .o_done      (w_done[g]),
      .o_data_out  (w_dout[g]),
      .o_shamt_out (w_shq[g])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (reset && w_done[g]) begin
        if (sb_q[g].size() == 0) begin
          check_eq($sformatf("spurious_done_s%0d", ST), 32'(w_done[g]), 32'd0);
        end else begin
          e = sb_q[g].pop_front();
          check_eq($sformatf("data_s%0d", ST), w_dout[g], e.data);
          check_eq($sformatf("latency_s%0d", ST), cyc, e.cyc);
          check_eq($sformatf("busy_at_done_s%0d", ST), 32'(w_busy[g]), 32'd0);
          if (e.chk_sh) check_eq($sformatf("shamt_s%0d", ST), 32'(w_shq[g]), 32'(e.shamt));
        end
      end
    end
  end

  function automatic logic [4:0] ref_amt(input logic [1:0] as, input logic [15:0] off,
                                         input logic [31:0] rb);
    case (as)
      2'b00:   return off[10:6];
      2'b01:   return 5'd16;
      2'b10:   return rb[4:0];
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] d,
                                            input logic [4:0] a);
    logic [63:0] t;
    case (o)
      SH_SLL: return d << a;
      SH_SRL: return d >> a;
      SH_SRA: begin t = {{32{d[31]}}, d} >> a; return t[31:0]; end
      SH_ROR: begin t = {d, d} >> a; return t[31:0]; end
      SH_ROL: begin t = {d, d} << a; return t[63:32]; end
      default: return d;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [1:0] as, input logic [15:0] off,
                          input logic [31:0] rb, input logic [31:0] d);
    logic [4:0] a;
    exp_t e;
    int t;
    @(negedge clk);
    op = o; amt_sel = as; offset = off; reg_b = rb; data_in = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = cyc;
    a = ref_amt(as, off, rb);
    // Sources are scrambled after acceptance; they must not affect the result.
    offset = 16'($urandom); reg_b = $urandom; data_in = $urandom;
    if (o == SH_LOAD || is_shift_op(o)) begin
      for (int g = 0; g < NI; g++) begin
        e.data   = (o == SH_LOAD) ? d : ref_shift(o, d, a);
        e.shamt  = a;
        e.chk_sh = (o != SH_LOAD);
        e.cyc    = (o == SH_LOAD) ? t
                 : t + (int'(a) + step_of(g) - 1) / step_of(g) + 2 - 1;
        sb_q[g].push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int pend;
    for (int i = 0; i < 200; i++) begin
      pend = 0;
      for (int g = 0; g < NI; g++) pend += sb_q[g].size();
      if (pend == 0) break;
      @(negedge clk);
    end
    check_eq("idle_timeout_pending", pend, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [1:0] as, input logic [15:0] off,
                        input logic [31:0] rb, input logic [31:0] d);
    start_op(o, as, off, rb, d);
    wait_idle();
  endtask

  initial begin
    #1;
    for (int g = 0; g < NI; g++) begin
      check_eq("rst_data", w_dout[g], 32'd0);
      check_eq("rst_shamt", 32'(w_shq[g]), 32'd0);
      check_eq("rst_busy", 32'(w_busy[g]), 32'd0);
      check_eq("rst_done", 32'(w_done[g]), 32'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // SLL by offset[10:6]=4, with busy profile on the STEP=1 instance
    start_op(SH_SLL, AMT_OFFSET, 16'h0100, 32'h0, 32'h0000_00F1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check_eq($sformatf("busy_s1_c%0d", c), 32'(w_busy[0]), (c <= 5) ? 32'd1 : 32'd0);
    end
    wait_idle();

    run_op(SH_SRA, AMT_REGB, 16'h0, 32'hFFFF_FFE8, 32'h8000_0000);
    run_op(SH_SRL, AMT_REGB, 16'h0, 32'hFFFF_FFE8, 32'h8000_0000);
    run_op(SH_ROL, AMT_CONST, 16'h0, 32'h0, 32'h1234_5678);
    run_op(SH_ROR, AMT_CONST, 16'h0, 32'h0, 32'h1234_5678);
    run_op(SH_SLL, AMT_ZERO, 16'hFFFF, 32'hFFFF_FFFF, 32'hA5A5_0F0F);
    run_op(SH_SLL, AMT_OFFSET, 16'h0000, 32'h0, 32'h1357_9BDF);
    run_op(SH_LOAD, AMT_OFFSET, 16'h0, 32'h0, 32'hDEAD_BEEF);
    run_op(SH_SRA, AMT_REGB, 16'h0, 32'h0000_001F, 32'h8000_0001);
    run_op(SH_ROL, AMT_REGB, 16'h0, 32'h0000_001F, 32'h8000_0001);
    run_op(SH_NOP, AMT_CONST, 16'h0, 32'h0, 32'h1111_1111);
    run_op(SH_NOP2, AMT_CONST, 16'h0, 32'h0, 32'h2222_2222);
    check_eq("nop_keeps_data", w_dout[0], 32'h8000_0001 << 31 | 32'h8000_0001 >> 1);

    // start re-asserted while shifting/done must be ignored
    start_op(SH_SLL, AMT_OFFSET, 16'd9 << 6, 32'h0, 32'h0000_00AB);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1; op = SH_SRL; amt_sel = AMT_CONST; data_in = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset in the middle of a 20-bit shift
    start_op(SH_SRL, AMT_OFFSET, 16'd20 << 6, 32'h0, 32'hF0F0_F0F0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      check_eq("midrst_data", w_dout[g], 32'd0);
      check_eq("midrst_shamt", 32'(w_shq[g]), 32'd0);
      check_eq("midrst_busy", 32'(w_busy[g]), 32'd0);
      check_eq("midrst_done", 32'(w_done[g]), 32'd0);
      sb_q[g].delete();
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(SH_ROR, AMT_OFFSET, 16'd20 << 6, 32'h0, 32'hF0F0_1234);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom),
             $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
